snvs_lp_zmk_ecc_chk: RTL and testbench

SNVS_LP_ZMK_ECC_CHK -- requirements
Module: snvs_lp_zmk_ecc_chk

---
 rtl/snvs_lp_zmk_ecc_chk_pkg.sv | 14 +
 rtl/snvs_lp_zmk_ecc_chk_fold.sv | 14 +
 rtl/snvs_lp_zmk_ecc_chk.sv | 121 ++++++++++++
 tb/tb_snvs_lp_zmk_ecc_chk.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/snvs_lp_zmk_ecc_chk_pkg.sv
// Shared SNVS parameters for the ZMK ECC checker: FSM states and data widths.
package snvs_lp_zmk_ecc_chk_pkg;

  localparam int ECC_W  = 9;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } zmk_ecc_state_e;

endpackage

// File: rtl/snvs_lp_zmk_ecc_chk_fold.sv
// Folds one 32-bit key word into its 9-bit ECC contribution.
module snvs_lp_zmk_ecc_fold
  import snvs_lp_zmk_ecc_chk_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_odd,
  output logic [ECC_W-1:0]  o_fold
);

  // Byte XOR feeds ecc[7:0]; only odd-indexed words feed the parity bit.
  assign o_fold = {i_odd & (^i_word),
                   i_word[31:24] ^ i_word[23:16] ^ i_word[15:8] ^ i_word[7:0]};

endmodule

// File: rtl/snvs_lp_zmk_ecc_chk.sv
// ZMK ECC checker: word-serial ECC scan with sticky mismatch flag.
// Optional periodic rescan from DONE when SNVS_ZMK_ECC_PERIODIC_EN is defined.
module snvs_lp_zmk_ecc_chk
  import snvs_lp_zmk_ecc_chk_pkg::*;
#(
  parameter int          ZMK_WIDTH     = 256,
  parameter logic [15:0] RESCAN_PERIOD = 16'hFFFF
) (
  input  logic                 ipg_clk,
  input  logic                 zmk_reset_b,
  input  logic [ZMK_WIDTH-1:0] lpzmk_reg,
  input  logic [ECC_W-1:0]     zmk_ecc_val,
  input  logic                 zmk_ecc_en,
  input  logic                 zmk_chg,
  input  logic                 fail_clr,
  output logic                 ecc_busy,
  output logic                 ecc_valid,
  output logic                 ecc_fail,
  output logic [ECC_W-1:0]     ecc_calc,
  output logic [1:0]           dbg_state
);

  localparam int N_WORDS = ZMK_WIDTH / WORD_W;
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  zmk_ecc_state_e   r_state;
  zmk_ecc_state_e   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [ECC_W-1:0] r_acc;
  logic [ECC_W-1:0] r_calc;
  logic             r_fail;
  logic             r_en_d;
  logic [WORD_W-1:0] w_word;
  logic [ECC_W-1:0] w_fold;
  logic             w_restart;
  logic             w_fold_en;
  logic             w_commit;
  logic             w_timer_hit;

  assign w_word = lpzmk_reg[int'(r_cnt)*WORD_W +: WORD_W];

  snvs_lp_zmk_ecc_fold u_fold (
    .i_word (w_word),
    .i_odd  (r_cnt[0]),
    .o_fold (w_fold)
  );

`ifdef SNVS_ZMK_ECC_PERIODIC_EN
  logic [15:0] r_timer;

  assign w_timer_hit = ((r_timer + 16'd1) == RESCAN_PERIOD);

  always_ff @(posedge ipg_clk or negedge zmk_reset_b) begin
    if (!zmk_reset_b) begin
      r_timer <= 16'd0;
    end else if (r_state == DONE && w_state_nxt == DONE) begin
      r_timer <= r_timer + 16'd1;
    end else begin
      r_timer <= 16'd0;
    end
  end
`else
  logic w_unused_period;
  assign w_unused_period = ^RESCAN_PERIOD;
  assign w_timer_hit     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (zmk_ecc_en && (!r_en_d || zmk_chg)) w_state_nxt = SCAN;
      SCAN: if (!zmk_chg && r_cnt == LAST_IDX) w_state_nxt = CMP;
      CMP:  w_state_nxt = zmk_chg ? SCAN : DONE;
      DONE: if (zmk_chg || w_timer_hit) w_state_nxt = SCAN;
      default: w_state_nxt = IDLE;
    endcase
    // Disable overrides every other transition.
    if (!zmk_ecc_en) w_state_nxt = IDLE;
  end

  // A restart is any fresh entry to SCAN or a key change while already scanning.
  assign w_restart = (w_state_nxt == SCAN) && ((r_state != SCAN) || zmk_chg);
  assign w_fold_en = (r_state == SCAN) && zmk_ecc_en && !zmk_chg;
  assign w_commit  = (r_state == CMP) && zmk_ecc_en && !zmk_chg;

  always_ff @(posedge ipg_clk or negedge zmk_reset_b) begin
    if (!zmk_reset_b) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_calc  <= '0;
      r_fail  <= 1'b0;
      r_en_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en_d  <= zmk_ecc_en;
      if (w_restart) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_fold_en) begin
        r_acc <= r_acc ^ w_fold;
        r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
      end
      if (w_commit) r_calc <= r_acc;
      // A mismatch in the same cycle as fail_clr keeps the flag set.
      if (w_commit && (r_acc != zmk_ecc_val)) begin
        r_fail <= 1'b1;
      end else if (fail_clr) begin
        r_fail <= 1'b0;
      end
    end
  end

  assign ecc_busy  = (r_state == SCAN) || (r_state == CMP);
  assign ecc_valid = (r_state == DONE);
  assign ecc_fail  = r_fail;
  assign ecc_calc  = r_calc;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_snvs_lp_zmk_ecc_chk.sv
// Self-checking bench for snvs_lp_zmk_ecc_chk: directed cases plus randomized
// scans against a byte/word level ECC model and a cycle-count timing model.
module tb_snvs_lp_zmk_ecc_chk;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] lpzmk_reg;
  logic [8:0]   zmk_ecc_val;
  logic         zmk_ecc_en;
  logic         zmk_chg;
  logic         fail_clr;
  logic         ecc_busy;
  logic         ecc_valid;
  logic         ecc_fail;
  logic [8:0]   ecc_calc;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic m_fail = 1'b0;

  always #5 clk = ~clk;

  snvs_lp_zmk_ecc_chk #(.ZMK_WIDTH(W), .RESCAN_PERIOD(16'd20)) dut (
    .ipg_clk     (clk),
    .zmk_reset_b (rst_n),
    .lpzmk_reg   (lpzmk_reg),
    .zmk_ecc_val (zmk_ecc_val),
    .zmk_ecc_en  (zmk_ecc_en),
    .zmk_chg     (zmk_chg),
    .fail_clr    (fail_clr),
    .ecc_busy    (ecc_busy),
    .ecc_valid   (ecc_valid),
    .ecc_fail    (ecc_fail),
    .ecc_calc    (ecc_calc),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model_ecc(input logic [W-1:0] k);
    logic [8:0] e;
    e = '0;
    for (int b = 0; b < W/8; b++) e[7:0] = e[7:0] ^ k[8*b +: 8];
    for (int w = 1; w < W/32; w += 2) e[8] = e[8] ^ (^k[32*w +: 32]);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_key();
    logic [W-1:0] k;
    for (int i = 0; i < W/32; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Starts a scan in the current cycle (cycle 0) by enable rise or zmk_chg,
  // optionally re-pulses zmk_chg with key2 at cycle abort_at, optionally
  // pulses fail_clr in the compare cycle; returns in the first DONE cycle.
  task automatic run_scan(input string tag, input logic [W-1:0] key, input logic [8:0] val,
                          input bit use_en, input int abort_at, input logic [W-1:0] key2,
                          input bit clr_cmp);
    int start;
    bit done;
    logic [W-1:0] fk;
    logic mism;
    start = 0;
    done = 0;
    fk = key;
    lpzmk_reg = key;
    zmk_ecc_val = val;
    if (use_en) zmk_ecc_en = 1'b1;
    else zmk_chg = 1'b1;
    for (int c = 1; c <= 30 && !done; c++) begin
      tick();
      zmk_chg = 1'b0;
      fail_clr = 1'b0;
      if (c == 1) begin
        chk({tag, "_busy_c1"}, ecc_busy, 1);
        chk({tag, "_valid_c1"}, ecc_valid, 0);
      end
      if (abort_at > 0 && c == abort_at) begin
        lpzmk_reg = key2;
        fk = key2;
        zmk_chg = 1'b1;
        start = c;
      end
      if (clr_cmp && c == start + 9) fail_clr = 1'b1;
      if (c == start + 9) chk({tag, "_valid_pre"}, ecc_valid, 0);
      if (c == start + 10) begin
        chk({tag, "_valid"}, ecc_valid, 1);
        chk({tag, "_busy_done"}, ecc_busy, 0);
        chk({tag, "_calc"}, ecc_calc, model_ecc(fk));
        mism = (model_ecc(fk) != val);
        m_fail = mism | (m_fail & ~clr_cmp);
        chk({tag, "_fail"}, ecc_fail, m_fail);
        done = 1;
      end
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [W-1:0] k;
    logic [W-1:0] k2;
    logic [8:0] v;
    int ab;
    bit cc;

    rst_n = 1'b0;
    lpzmk_reg = '0;
    zmk_ecc_val = '0;
    zmk_ecc_en = 1'b0;
    zmk_chg = 1'b0;
    fail_clr = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rst_busy", ecc_busy, 0);
    chk("rst_valid", ecc_valid, 0);
    chk("rst_fail", ecc_fail, 0);
    chk("rst_calc", ecc_calc, 0);
    chk("rst_state", dbg_state, 0);

    run_scan("zero", '0, 9'h000, 1, 0, '0, 0);
    chk("zero_calc_const", ecc_calc, 9'h000);

    k = '0;
    k[31:0] = 32'h000000FF;
    run_scan("w0ff", k, 9'h000, 0, 0, '0, 0);
    chk("w0ff_calc_const", ecc_calc, 9'h0FF);
    chk("w0ff_fail_const", ecc_fail, 1);

    k = '0;
    k[63:32] = 32'h00000001;
    run_scan("w1", k, 9'h101, 0, 0, '0, 0);
    chk("w1_calc_const", ecc_calc, 9'h101);
    fail_clr = 1'b1;
    tick();
    fail_clr = 1'b0;
    m_fail = 1'b0;
    chk("clr_in_done", ecc_fail, 0);
    run_scan("w1_clr", k, 9'h101, 0, 0, '0, 1);

    k = '0;
    k[31:0] = 32'h000000FF;
    run_scan("set_wins", k, 9'h000, 0, 0, '0, 1);

    k = rand_key();
    k2 = rand_key();
    run_scan("abort_w4", k, model_ecc(k2), 0, 5, k2, 0);

    zmk_ecc_en = 1'b0;
    tick();
    chk("dis_state", dbg_state, 0);
    chk("dis_valid", ecc_valid, 0);
    chk("dis_fail", ecc_fail, m_fail);
    run_scan("reen", rand_key(), $urandom_range(0, 511), 1, 0, '0, 0);

    for (int it = 0; it < 24; it++) begin
      k = rand_key();
      k2 = rand_key();
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : 0;
      cc = ($urandom_range(0, 3) == 0);
      v = (ab > 0) ? model_ecc(k2) : model_ecc(k);
      if ($urandom_range(0, 1) == 1) v = $urandom_range(0, 511);
      run_scan("rnd", k, v, 0, ab, k2, cc);
      if ($urandom_range(0, 4) == 0) begin
        fail_clr = 1'b1;
        tick();
        fail_clr = 1'b0;
        m_fail = 1'b0;
        chk("rnd_clr", ecc_fail, 0);
      end
    end

    k = '0;
    k[31:0] = 32'h000000FF;
    run_scan("pre_rst", k, 9'h000, 0, 0, '0, 0);
    zmk_ecc_en = 1'b0;
    tick();
    run_scan("pre_rst2", rand_key(), 9'h000, 1, 0, '0, 0);
    zmk_ecc_en = 1'b0;
    tick();
    zmk_ecc_en = 1'b1;
    lpzmk_reg = rand_key();
    for (int i = 0; i < 4; i++) tick();
    chk("mid_scan_busy", ecc_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", ecc_busy, 0);
    chk("arst_valid", ecc_valid, 0);
    chk("arst_fail", ecc_fail, 0);
    chk("arst_calc", ecc_calc, 0);
    chk("arst_state", dbg_state, 0);
    m_fail = 1'b0;
    zmk_ecc_en = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_state", dbg_state, 0);
    chk("post_rst_busy", ecc_busy, 0);
    run_scan("post_rst", rand_key(), 9'h000, 1, 0, '0, 0);

`ifdef SNVS_ZMK_ECC_PERIODIC_EN
    for (int i = 1; i <= 19; i++) tick();
    chk("periodic_idle_19", ecc_busy, 0);
    tick();
    chk("periodic_busy_20", ecc_busy, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
